// File: rtl/spi_pkg.sv
// spi_pkg: constants shared by the SPI receive-side parser and the transmit-side sequencer.
//   RC_CMD_*  command byte codes seen as the first byte of a frame
//   rcState_t parser state encoding (also decoded by the transmit sequencer)
package spi_pkg;

   localparam logic [7:0] RC_CMD_GET_STATUS = 8'h00;
   localparam logic [7:0] RC_CMD_GET_BUFFER = 8'h01;
   localparam logic [7:0] RC_CMD_PUT_BUFFER = 8'h02;

   typedef enum logic [1:0] {
      RC_ST_CMD     = 2'd0,
      RC_ST_SIZE    = 2'd1,
      RC_ST_PAYLOAD = 2'd2,
      RC_ST_DISCARD = 2'd3
   } rcState_t;

endpackage

// File: rtl/spi_size_counter.sv
// spi_size_counter: assembles the big-endian 32-bit payload size and counts payload bytes.
//   clear     zero size, count and byte index (new buffer command)
//   sizeLoad  merge sizeByte into the size at the current byte index
//   step      advance the payload byte count
//   sizeNext  size including sizeByte at the current index (valid during sizeLoad)
//   sizeFinal the current size byte is the fourth (last) one
//   countLast count == size-1, full 32-bit compare
//   countOver count has passed the buffer capacity 2^AddrBits
//   countAddr low AddrBits of count, the buffer address
module spi_size_counter #(
   parameter int unsigned AddrBits = 12
) (
   input  logic                SysClk,
   input  logic                Reset_n,
   input  logic                clear,
   input  logic                sizeLoad,
   input  logic                step,
   input  logic [7:0]          sizeByte,
   output logic [31:0]         sizeNext,
   output logic                sizeFinal,
   output logic                countLast,
   output logic                countOver,
   output logic [AddrBits-1:0] countAddr
);

   logic [31:0] sizeQ;
   logic [31:0] countQ;
   logic [1:0]  sizeIdxQ;

   always_comb begin
      sizeNext = sizeQ;
      unique case (sizeIdxQ)
         2'd0: sizeNext[31:24] = sizeByte;
         2'd1: sizeNext[23:16] = sizeByte;
         2'd2: sizeNext[15:8]  = sizeByte;
         2'd3: sizeNext[7:0]   = sizeByte;
      endcase
   end

   assign sizeFinal = (sizeIdxQ == 2'd3);
   // PAYLOAD is only entered with a non-zero size, so size-1 never wraps there.
   assign countLast = (countQ == (sizeQ - 32'd1));
   assign countOver = |countQ[31:AddrBits];
   assign countAddr = countQ[AddrBits-1:0];

   always_ff @(posedge SysClk or negedge Reset_n) begin
      if (!Reset_n) begin
         sizeQ    <= '0;
         countQ   <= '0;
         sizeIdxQ <= '0;
      end else if (clear) begin
         sizeQ    <= '0;
         countQ   <= '0;
         sizeIdxQ <= '0;
      end else if (sizeLoad) begin
         sizeQ    <= sizeNext;
         sizeIdxQ <= sizeIdxQ + 2'd1;
      end else if (step) begin
         countQ <= countQ + 32'd1;
      end
   end

endmodule

// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: decodes the SPI receive byte stream into commands and buffer writes.
//   SysClk, Reset_n        clock, asynchronous active-low reset
//   ssStart                new frame strobe (SS fell)
//   rcByteValid, rcByte    received byte strobe and data
//   rcMemAddr/Data/WE      receive-buffer write port, one WE pulse per stored payload byte
//   txAddrReset            pulse when a GET_BUFFER frame's size is complete
//   frameDone              pulse when a frame's payload completes normally
//   overflow               sticky: PUT payload ran past the buffer, cleared by ssStart
//   debug_out              {state, mode, overflow, 3'b0}
module spi_cmd_parser
   import spi_pkg::*;
#(
   parameter int unsigned AddrBits = 12
) (
   input  logic                SysClk,
   input  logic                Reset_n,
   input  logic                ssStart,
   input  logic                rcByteValid,
   input  logic [7:0]          rcByte,
   output logic [AddrBits-1:0] rcMemAddr,
   output logic [7:0]          rcMemData,
   output logic                rcMemWE,
   output logic                txAddrReset,
   output logic                frameDone,
   output logic                overflow,
   output logic [7:0]          debug_out
);

   rcState_t            stateQ, stateD, effState;
   logic [1:0]          modeQ, modeD;
   logic                cntClear, cntLoad, cntStep;
   logic [31:0]         sizeNext;
   logic                sizeFinal, countLast, countOver;
   logic [AddrBits-1:0] countAddr;
   logic                weD, txRstD, doneD, ovfD;
   logic [AddrBits-1:0] addrD;
   logic [7:0]          dataD;

   spi_size_counter #(
      .AddrBits (AddrBits)
   ) uSizeCounter (
      .SysClk    (SysClk),
      .Reset_n   (Reset_n),
      .clear     (cntClear),
      .sizeLoad  (cntLoad),
      .step      (cntStep),
      .sizeByte  (rcByte),
      .sizeNext  (sizeNext),
      .sizeFinal (sizeFinal),
      .countLast (countLast),
      .countOver (countOver),
      .countAddr (countAddr)
   );

   // ssStart wins: a coincident byte is decoded as the new frame's command.
   assign effState = ssStart ? RC_ST_CMD : stateQ;

   always_ff @(posedge SysClk or negedge Reset_n) begin
      if (!Reset_n) begin
         stateQ <= RC_ST_CMD;
         modeQ  <= '0;
      end else begin
         stateQ <= stateD;
         modeQ  <= modeD;
      end
   end

   always_comb begin
      stateD   = effState;
      modeD    = modeQ;
      cntClear = 1'b0;
      cntLoad  = 1'b0;
      cntStep  = 1'b0;
      if (rcByteValid) begin
         unique case (effState)
            RC_ST_CMD: begin
               if (rcByte == RC_CMD_GET_BUFFER || rcByte == RC_CMD_PUT_BUFFER) begin
                  stateD   = RC_ST_SIZE;
                  modeD    = rcByte[1:0];
                  cntClear = 1'b1;
               end else if (rcByte != RC_CMD_GET_STATUS) begin
                  stateD = RC_ST_DISCARD;
               end
            end
            RC_ST_SIZE: begin
               cntLoad = 1'b1;
               if (sizeFinal) begin
                  stateD = (sizeNext == 32'd0) ? RC_ST_CMD : RC_ST_PAYLOAD;
               end
            end
            RC_ST_PAYLOAD: begin
               if (countLast) begin
                  stateD = RC_ST_CMD;
               end else begin
                  cntStep = 1'b1;
               end
            end
            RC_ST_DISCARD: ;
         endcase
      end
   end

   always_comb begin
      weD    = 1'b0;
      addrD  = rcMemAddr;
      dataD  = rcMemData;
      txRstD = 1'b0;
      doneD  = 1'b0;
      ovfD   = ssStart ? 1'b0 : overflow;
      if (rcByteValid) begin
         unique case (effState)
            RC_ST_SIZE: begin
               if (sizeFinal) begin
                  txRstD = (modeQ == RC_CMD_GET_BUFFER[1:0]);
                  doneD  = (sizeNext == 32'd0);
               end
            end
            RC_ST_PAYLOAD: begin
               if (modeQ == RC_CMD_PUT_BUFFER[1:0]) begin
                  // Past capacity the byte is dropped; addresses never wrap.
                  if (countOver) begin
                     ovfD = 1'b1;
                  end else begin
                     weD   = 1'b1;
                     addrD = countAddr;
                     dataD = rcByte;
                  end
               end
               doneD = countLast;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge SysClk or negedge Reset_n) begin
      if (!Reset_n) begin
         rcMemWE     <= 1'b0;
         rcMemAddr   <= '0;
         rcMemData   <= '0;
         txAddrReset <= 1'b0;
         frameDone   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         rcMemWE     <= weD;
         rcMemAddr   <= addrD;
         rcMemData   <= dataD;
         txAddrReset <= txRstD;
         frameDone   <= doneD;
         overflow    <= ovfD;
      end
   end

   assign debug_out = {stateQ, modeQ, overflow, 3'b000};

endmodule

// File: tb/tb_spi_cmd_parser.sv
module tb_spi_cmd_parser;

   localparam int unsigned AB  = 2;
   localparam int          Cap = 1 << AB;

   logic          SysClk = 1'b0;
   logic          Reset_n;
   logic          ssStart;
   logic          rcByteValid;
   logic [7:0]    rcByte;
   logic [AB-1:0] rcMemAddr;
   logic [7:0]    rcMemData;
   logic          rcMemWE;
   logic          txAddrReset;
   logic          frameDone;
   logic          overflow;
   logic [7:0]    debug_out;

   int checks   = 0;
   int failures = 0;

   spi_cmd_parser #(
      .AddrBits (AB)
   ) dut (
      .SysClk      (SysClk),
      .Reset_n     (Reset_n),
      .ssStart     (ssStart),
      .rcByteValid (rcByteValid),
      .rcByte      (rcByte),
      .rcMemAddr   (rcMemAddr),
      .rcMemData   (rcMemData),
      .rcMemWE     (rcMemWE),
      .txAddrReset (txAddrReset),
      .frameDone   (frameDone),
      .overflow    (overflow),
      .debug_out   (debug_out)
   );

   always #5 SysClk = ~SysClk;

   // Reference model: frames are tracked as "bytes seen since the command byte";
   // bytes 0-3 after the command form the size, later bytes are payload index n-4.
   int            kind;   // 0 awaiting command, 1 buffer frame active, 3 discarding
   longint        n;
   longint        mSize;
   logic [1:0]    mMode;
   logic          eWe, eTx, eDone, eOvf;
   logic [AB-1:0] eAddr;
   logic [7:0]    eData;

   task automatic modelReset();
      kind = 0; n = 0; mSize = 0; mMode = 2'd0;
      eWe = 0; eTx = 0; eDone = 0; eOvf = 0; eAddr = '0; eData = '0;
   endtask

   function automatic logic [1:0] expSt();
      if (kind == 0) return 2'd0;
      if (kind == 3) return 2'd3;
      return (n < 4) ? 2'd1 : 2'd2;
   endfunction

   task automatic modelApply(input logic s, input logic v, input logic [7:0] b);
      longint k;
      eWe = 0; eTx = 0; eDone = 0;
      if (s) begin
         kind = 0;
         eOvf = 0;
      end
      if (v) begin
         if (kind == 0) begin
            if (b == 8'h01 || b == 8'h02) begin
               kind = 1; mMode = b[1:0]; n = 0; mSize = 0;
            end else if (b != 8'h00) begin
               kind = 3;
            end
         end else if (kind == 1) begin
            if (n < 4) begin
               mSize = mSize * 256 + longint'(b);
               n++;
               if (n == 4) begin
                  if (mMode == 2'd1) eTx = 1;
                  if (mSize == 0) begin
                     eDone = 1; kind = 0;
                  end
               end
            end else begin
               k = n - 4;
               if (mMode == 2'd2) begin
                  if (k < Cap) begin
                     eWe = 1; eAddr = k[AB-1:0]; eData = b;
                  end else begin
                     eOvf = 1;
                  end
               end
               if (k == mSize - 1) begin
                  eDone = 1; kind = 0;
               end
               n++;
            end
         end
      end
   endtask

   task automatic check(input string name);
      logic [21:0] act, exp;
      act = {rcMemWE, rcMemAddr, rcMemData, txAddrReset, frameDone, overflow, debug_out};
      exp = {eWe, eAddr, eData, eTx, eDone, eOvf, expSt(), mMode, eOvf, 3'b000};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t: got we=%b addr=%0d data=%h tx=%b done=%b ovf=%b dbg=%h, want we=%b addr=%0d data=%h tx=%b done=%b ovf=%b dbg=%h",
                  name, $time, rcMemWE, rcMemAddr, rcMemData, txAddrReset, frameDone, overflow,
                  debug_out, eWe, eAddr, eData, eTx, eDone, eOvf,
                  {expSt(), mMode, eOvf, 3'b000});
      end
   endtask

   // Drive one cycle of inputs, advance the model, compare one cycle later.
   task automatic step(input logic s, input logic v, input logic [7:0] b, input string name);
      ssStart = s; rcByteValid = v; rcByte = b;
      modelApply(s, v, b);
      @(posedge SysClk);
      #1;
      ssStart = 1'b0; rcByteValid = 1'b0; rcByte = 8'h00;
      check(name);
   endtask

   task automatic sizeBytes(input logic [31:0] sz, input string name);
      for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, sz[i*8 +: 8], name);
   endtask

   typedef struct {
      logic       ss;
      logic       v;
      logic [7:0] b;
      logic       we;
      logic [1:0] addr;
      logic [7:0] data;
      logic       tx;
      logic       done;
      logic [7:0] dbg;
   } vec_t;

   vec_t tbl [10];

   initial begin
      logic [20:0] act, exp;
      int          c, k, plen;
      logic [7:0]  cmd;

      // PUT_BUFFER 02, size 3, payload 11 22 33 back-to-back, right after reset.
      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 8'h02, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h60};
      tbl[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h60};
      tbl[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h60};
      tbl[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'h60};
      tbl[5] = '{1'b0, 1'b1, 8'h03, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 8'hA0};
      tbl[6] = '{1'b0, 1'b1, 8'h11, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 8'hA0};
      tbl[7] = '{1'b0, 1'b1, 8'h22, 1'b1, 2'd1, 8'h22, 1'b0, 1'b0, 8'hA0};
      tbl[8] = '{1'b0, 1'b1, 8'h33, 1'b1, 2'd2, 8'h33, 1'b0, 1'b1, 8'h20};
      tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 8'h33, 1'b0, 1'b0, 8'h20};

      Reset_n = 1'b0; ssStart = 1'b0; rcByteValid = 1'b0; rcByte = 8'h00;
      modelReset();
      #12;
      check("reset_initial");
      Reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         ssStart = tbl[i].ss; rcByteValid = tbl[i].v; rcByte = tbl[i].b;
         modelApply(tbl[i].ss, tbl[i].v, tbl[i].b);
         @(posedge SysClk);
         #1;
         ssStart = 1'b0; rcByteValid = 1'b0;
         act = {rcMemWE, rcMemAddr, rcMemData, txAddrReset, frameDone, debug_out};
         exp = {tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].tx, tbl[i].done, tbl[i].dbg};
         checks++;
         if (act !== exp) begin
            failures++;
            $display("FAIL put_table[%0d]: got %h want %h", i, act, exp);
         end
      end

      // GET_BUFFER: txAddrReset on 4th size byte, no writes, done after 2nd filler.
      step(1'b1, 1'b0, 8'h00, "get_ss");
      step(1'b0, 1'b1, 8'h01, "get_cmd");
      sizeBytes(32'd2, "get_size");
      step(1'b0, 1'b1, 8'hFF, "get_fill");
      step(1'b0, 1'b1, 8'hFF, "get_done");

      // Size 0: immediate frameDone, no payload.
      step(1'b1, 1'b0, 8'h00, "sz0_ss");
      step(1'b0, 1'b1, 8'h02, "sz0_cmd");
      sizeBytes(32'd0, "sz0_size");
      step(1'b0, 1'b0, 8'h00, "sz0_idle");

      // Size 6 with capacity 4: writes 0-3, then sticky overflow until ssStart.
      step(1'b1, 1'b0, 8'h00, "ovf_ss");
      step(1'b0, 1'b1, 8'h02, "ovf_cmd");
      sizeBytes(32'd6, "ovf_size");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'hC0 + 8'(i), "ovf_payload");
      step(1'b0, 1'b0, 8'h00, "ovf_sticky");
      step(1'b0, 1'b0, 8'h00, "ovf_sticky");
      step(1'b1, 1'b0, 8'h00, "ovf_clear");

      // Abort mid-payload: no frameDone.
      step(1'b0, 1'b1, 8'h02, "abort_cmd");
      sizeBytes(32'd5, "abort_size");
      step(1'b0, 1'b1, 8'hA1, "abort_payload");
      step(1'b1, 1'b0, 8'h00, "abort_ss");
      step(1'b0, 1'b0, 8'h00, "abort_idle");

      // ssStart coincident with command byte: decoded, state SIZE.
      step(1'b1, 1'b1, 8'h02, "collide_cmd");
      sizeBytes(32'd1, "collide_size");
      step(1'b0, 1'b1, 8'h5A, "collide_payload");

      // Unknown command discards the rest of the frame.
      step(1'b1, 1'b0, 8'h00, "unk_ss");
      step(1'b0, 1'b1, 8'h7E, "unk_cmd");
      step(1'b0, 1'b1, 8'h02, "unk_discard");
      sizeBytes(32'd1, "unk_discard");
      step(1'b0, 1'b1, 8'h55, "unk_discard");

      // GET_STATUS stays in CMD, so the next byte is a fresh command.
      step(1'b1, 1'b0, 8'h00, "status_ss");
      step(1'b0, 1'b1, 8'h00, "status_cmd");
      step(1'b0, 1'b1, 8'h02, "status_next_cmd");

      // Large size: full-width compare, aborted after a few bytes.
      step(1'b1, 1'b1, 8'h02, "big_cmd");
      sizeBytes(32'hFFFF_FFFF, "big_size");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(i), "big_payload");

      // Asynchronous reset mid-payload, held for 3 cycles.
      step(1'b1, 1'b0, 8'h00, "rst_ss");
      step(1'b0, 1'b1, 8'h02, "rst_cmd");
      sizeBytes(32'd6, "rst_size");
      ssStart = 1'b0; rcByteValid = 1'b1; rcByte = 8'h11;
      #2;
      Reset_n = 1'b0;
      modelReset();
      #1;
      rcByteValid = 1'b0;
      check("reset_async");
      for (int i = 0; i < 3; i++) begin
         @(posedge SysClk);
         #1;
         check("reset_hold");
      end
      Reset_n = 1'b1;
      step(1'b1, 1'b0, 8'h00, "post_rst_ss");
      step(1'b0, 1'b1, 8'h02, "post_rst_cmd");
      sizeBytes(32'd2, "post_rst_size");
      step(1'b0, 1'b1, 8'hAA, "post_rst_aa");
      step(1'b0, 1'b1, 8'hBB, "post_rst_bb");
      step(1'b0, 1'b0, 8'h00, "post_rst_idle");

      // Randomized frames against the model.
      for (int f = 0; f < 250; f++) begin
         c = $urandom_range(0, 9);
         cmd = (c < 4) ? 8'h02 : (c < 7) ? 8'h01 : (c < 8) ? 8'h00 : 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) begin
            step(1'b1, 1'b1, cmd, "rnd_cmd_collide");
         end else begin
            step(1'b1, 1'b0, 8'h00, "rnd_ss");
            step(1'b0, 1'b1, cmd, "rnd_cmd");
         end
         for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 "rnd_size");
         end
         k = $urandom_range(0, 7);
         step(1'b0, 1'b1, 8'(k), "rnd_size");
         plen = $urandom_range(0, 10);
         for (int j = 0; j < plen; j++) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 8'h00, "rnd_gap");
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)), "rnd_payload");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_cmd_parser.md
# spi_cmd_parser

Byte-level command parser that sits directly downstream of the SPI slave receiver in the SysClk domain. Consumes the received byte stream plus a frame-start strobe, decodes the framing, and drives the receive-buffer memory port. A frame is one command byte, then for buffer commands a big-endian 32-bit payload size, then the payload. Also tells the transmit side when a GET_BUFFER frame begins.

## Interface
- AddrBits, 12, width of receive-buffer address; buffer capacity is 2^AddrBits bytes.

- SysClk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- ssStart  in  1  one-cycle pulse: SPI_SS fell, so a new frame begins.
- rcByteValid  in  1  one-cycle pulse: rcByte holds a complete received byte.
- rcByte  in  8  received byte, valid only with rcByteValid.
- rcMemAddr  out  AddrBits  receive-buffer write address.
- rcMemData  out  8  receive-buffer write data.
- rcMemWE  out  1  receive-buffer write enable, one-cycle pulse per payload byte.
- txAddrReset  out  1  one-cycle pulse: the transmit byte address returns to 0.
- frameDone  out  1  one-cycle pulse when a payload completes normally.
- overflow  out  1  sticky flag: payload exceeded capacity. Cleared by ssStart.
- debug_out  out  8  {state[1:0], mode[1:0], overflow, 3'b0}.

## Operation
- Commands: GET_STATUS=8'h00, GET_BUFFER=8'h01, PUT_BUFFER=8'h02. Any other value is unknown.
- States: CMD, SIZE, PAYLOAD, DISCARD. Registers: mode (2b), size (32b), count (32b), sizeIdx (2b).
- CMD state, on a byte:
  - 00 → stay in CMD. No side effects.
  - 01 or 02 → latch mode, clear size, clear count, clear sizeIdx, go to SIZE.
  - Unknown → go to DISCARD.
- SIZE state: each byte fills size MSB first, in this order:
  - sizeIdx 0 → size[31:24]
  - sizeIdx 1 → size[23:16]
  - sizeIdx 2 → size[15:8]
  - sizeIdx 3 → size[7:0]
- After the fourth size byte:
  - Final size 0 → return to CMD, pulse frameDone, no payload.
  - Otherwise → go to PAYLOAD.
  - In GET_BUFFER mode, txAddrReset pulses on this same byte.
- PAYLOAD state, per byte:
  - PUT_BUFFER with count < 2^AddrBits → rcMemWE=1, rcMemData=byte, rcMemAddr=count[AddrBits-1:0].
  - PUT_BUFFER with count ≥ 2^AddrBits → no write; set overflow. Addresses never wrap.
  - GET_BUFFER → byte ignored (it is filler while the host clocks data out).
  - count == size-1 → go to CMD and pulse frameDone. Otherwise count increments.
- DISCARD: ignore all bytes until ssStart.
- ssStart from any state → go to CMD, clear overflow, and abort any in-progress frame without pulsing frameDone. Memory writes already issued stand.
- ssStart and rcByteValid in the same cycle: ssStart is applied first, and the byte is decoded as the command byte of the new frame.
- count is 32-bit and compared against size in full width. size=32'hFFFFFFFF is legal; count must not overflow before the match.

## Timing
- Every output is registered.
- rcMemWE, rcMemData and rcMemAddr appear one cycle after the payload rcByteValid.
- txAddrReset and frameDone appear one cycle after the byte that triggers them.
- Back-to-back rcByteValid on consecutive cycles must be supported; there is no backpressure.
- Values while Reset_n is low:
  - state=CMD, mode=0, size=0, count=0, sizeIdx=0
  - rcMemAddr=0, rcMemData=0
  - rcMemWE=0, txAddrReset=0, frameDone=0, overflow=0
  - debug_out=0
- Reset asserted mid-frame → immediate return to those values, with no partial write pulse.
- rcMemAddr and rcMemData hold their last values while rcMemWE=0.

## Structure
- Shared package spi_pkg holds:
  - command codes RC_CMD_GET_STATUS, RC_CMD_GET_BUFFER, RC_CMD_PUT_BUFFER
  - state encoding RC_ST_CMD=0, RC_ST_SIZE=1, RC_ST_PAYLOAD=2, RC_ST_DISCARD=3
- Both are reused by the transmit-side sequencer.
- One natural sub-module: spi_size_counter. It holds the 32-bit size assembly, the count register, and the last/overflow compare, controlled by load/step/clear strobes from the FSM.

## Test plan
- Reset: hold Reset_n low for 3 cycles mid-payload → all outputs 0, state CMD. The next ssStart, 02, 00 00 00 02, AA BB frame writes AA@0 and BB@1.
- PUT_BUFFER normal: ssStart, 02, 00 00 00 03, 11 22 33 with bytes back-to-back → WE pulses at addr 0,1,2 with data 11,22,33, then frameDone once, one cycle after the 33 byte.
- GET_BUFFER: ssStart, 01, 00 00 00 02, FF FF → txAddrReset pulses once, after the fourth size byte; rcMemWE never asserts; frameDone follows the second FF.
- Boundaries with AddrBits=2:
  - size 0 (ssStart, 02, 00 00 00 00) → frameDone, no WE.
  - size 6 → writes at addr 0-3 only; overflow=1 from the fifth payload byte until the next ssStart.
- Abort/collision: ssStart during PAYLOAD of a 02 frame → no frameDone. ssStart coincident with byte 02 → the byte is decoded as the command and the state goes to SIZE.
- Unknown/status: ssStart, 7E, 02, 00 00 00 01, 55 → DISCARD, no WE. ssStart, 00, 02 → state SIZE, showing GET_STATUS stays in CMD.
